// File: rtl/nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Performs a W = 4*NIBBLES bit unsigned subtraction (a - b mod 2^W) one
// nibble per clock through an external combinational 4-bit ripple-carry
// subtractor stage. This block feeds that stage its operand nibbles and
// carry-in, chains the carry, and assembles the full-width result.
//
// Optional feature macro: SUB_OVF_EN
//   When defined, a signed-overflow flag is registered on completion.
//   When undefined, ovf is tied to 0 and no overflow logic exists.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only when busy=0
//   a, b             minuend / subtrahend, captured on the accepted start
//   sub_a, sub_b     current nibble to the stage (true b; stage inverts)
//   sub_bin          stage carry-in (1 = no borrow)
//   sub_diff         stage difference
//   sub_bout         stage carry-out (1 = no borrow)
//   diff             full-width result, held until the next completion
//   borrow           1 when a < b (unsigned)
//   ovf              signed overflow flag (0 unless SUB_OVF_EN)
//   busy             high while nibbles are being processed
//   done             one-cycle pulse, result valid
// ---------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic [3:0]           sub_a,
  output logic [3:0]           sub_b,
  output logic                 sub_bin,
  input  logic [3:0]           sub_diff,
  input  logic                 sub_bout,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 borrow,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             accept;
  logic             last_nib;
  logic [IDX_W+1:0] nib_lsb;

  // DONE counts as not busy, so a start there is taken just like in IDLE.
  assign accept   = start && (state_q != S_RUN);
  assign last_nib = (idx_q == LAST_IDX);
  assign nib_lsb  = {idx_q, 2'b00};

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: operand registers are reset too; they are plain flops, not a
  // memory array, so the reset costs nothing and keeps sub_* deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last_nib) state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    if (accept) begin
      a_d   = a;
      b_d   = b;
      idx_d = '0;
    end

    if (state_q == S_RUN) begin
      diff_d[nib_lsb +: 4] = sub_diff;
      carry_d              = sub_bout;
      if (last_nib) begin
        // Final carry-out of 0 means the whole subtraction borrowed.
        borrow_d = ~sub_bout;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands of opposite sign and the result sign differs
  // from the minuend. The result MSB is the stage output of the last nibble.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last_nib) begin
      ovf_d = (a_q[W-1] != b_q[W-1]) && (sub_diff[3] != a_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    sub_a   = 4'h0;
    sub_b   = 4'h0;
    sub_bin = 1'b1;
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    if (state_q == S_RUN) begin
      sub_a   = a_q[nib_lsb +: 4];
      sub_b   = b_q[nib_lsb +: 4];
      // Lowest nibble starts with no borrow; later ones chain the carry.
      sub_bin = (idx_q == '0) ? 1'b1 : carry_q;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_subtractor
//
// Drives nibble_serial_subtractor (NIBBLES=4) connected to a behavioural
// 4-bit carry-style subtractor stage, and compares every completion against
// plain-arithmetic expectations for a - b on 16-bit operands.
// ---------------------------------------------------------------------------
module tb_nibble_serial_subtractor;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sub_a;
  logic [3:0]   sub_b;
  logic         sub_bin;
  logic [3:0]   sub_diff;
  logic         sub_bout;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_bin  (sub_bin),
    .sub_diff (sub_diff),
    .sub_bout (sub_bout),
    .diff     (diff),
    .borrow   (borrow),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  // The external 4-bit stage: a + ~b + cin, carry-out of 1 means no borrow.
  logic [4:0] stage_sum;
  always_comb begin
    stage_sum = {1'b0, sub_a} + {1'b0, ~sub_b} + {4'b0000, sub_bin};
    sub_diff  = stage_sum[3:0];
    sub_bout  = stage_sum[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed overflow of the 16-bit two's-complement subtraction.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic logic exp_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SUB_OVF_EN
    return model_ovf(x, y);
`else
    return 1'b0;
`endif
  endfunction

  // One operation. If inject_at > 0, a second start with other operands is
  // pulsed at that RUN cycle; it must be ignored.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input int inject_at, input logic [W-1:0] inj_a,
                        input logic [W-1:0] inj_b);
    logic [W-1:0] exp_diff;
    int           busy_cnt;
    int           lat;
    int           extra_done;
    bit           got;
    logic [31:0]  mask;
    exp_diff = op_a - op_b;
    busy_cnt = 0;
    lat      = 0;
    got      = 1'b0;

    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (busy) begin
        // Lower nibbles borrow-free exactly when their unsigned slice of a >= b.
        mask = (32'd1 << (4 * busy_cnt)) - 32'd1;
        check("sub_bin", {31'd0, sub_bin},
              (busy_cnt == 0) ? 32'd1 :
              {31'd0, (({16'd0, op_a} & mask) >= ({16'd0, op_b} & mask))});
        check("sub_a", {28'd0, sub_a}, (32'(op_a) >> (4 * busy_cnt)) & 32'hF);
        check("sub_b", {28'd0, sub_b}, (32'(op_b) >> (4 * busy_cnt)) & 32'hF);
        busy_cnt++;
      end
      if (done) begin
        got = 1'b1;
        lat = n;
      end
      if (inject_at > 0 && n == inject_at) begin
        a     = inj_a;
        b     = inj_b;
        start = 1'b1;
      end else if (inject_at > 0 && n == inject_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", lat, NIBBLES + 1);
    check("busy_cycles", busy_cnt, NIBBLES);
    check("diff", {16'd0, diff}, {16'd0, exp_diff});
    check("borrow", {31'd0, borrow}, {31'd0, op_a < op_b});
    check("ovf", {31'd0, ovf}, {31'd0, exp_ovf(op_a, op_b)});

    extra_done = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("single_done", extra_done, 0);
    check("diff_hold", {16'd0, diff}, {16'd0, exp_diff});
  endtask

  initial begin
    int extra_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_flags", {28'd0, borrow, ovf, busy, done}, 32'd0);
    check("rst_sub_bin", {31'd0, sub_bin}, 32'd1);
    check("rst_sub_ab", {24'd0, sub_a, sub_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(16'h1234, 16'h0234, 0, '0, '0);
    run_op(16'h0000, 16'h0001, 0, '0, '0);
    run_op(16'h8000, 16'h0001, 0, '0, '0);
    run_op(16'h7FFF, 16'hFFFF, 0, '0, '0);
    run_op(16'h00FF, 16'h0001, 2, 16'h1111, 16'h1111);
    run_op(16'hFFFF, 16'hFFFF, 0, '0, '0);

    // Start held high: back-to-back operations every NIBBLES+1 cycles.
    @(negedge clk);
    a     = 16'h5555;
    b     = 16'h1111;
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      check("held_done", {31'd0, done}, {31'd0, (n % 5) == 0});
      check("held_busy", {31'd0, busy}, {31'd0, (n % 5) != 0});
      if ((n % 5) == 0) check("held_diff", {16'd0, diff}, 32'h4444);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the third RUN cycle abandons the operation.
    @(negedge clk);
    a     = 16'h1234;
    b     = 16'h0234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_diff", {16'd0, diff}, 32'd0);
    check("mid_rst_flags", {28'd0, borrow, ovf, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("no_done_after_rst", extra_done, 0);
    run_op(16'hBEEF, 16'h1234, 0, '0, '0);

    // Randomized operations, biased toward interesting sign bits.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra[W-1] = ~rb[W-1];
      run_op(ra, rb, 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Sequencer that performs a wide (4·NIBBLES-bit) subtraction one nibble per clock through the team's existing 4-bit ripple-carry subtractor stage. It is that stage's neighbour on both sides:
- it feeds the stage its operand nibbles and borrow-in;
- it consumes the stage's difference and borrow-out, chaining the borrow and assembling the full-width result.

The 4-bit subtractor is instantiated externally (or by the integrating top) and connected through the sub_* ports.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range 2..8.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  W  minuend, captured on the accepted start edge.
- b  in  W  subtrahend, captured on the accepted start edge.
- sub_a  out  4  minuend nibble to subtractor stage.
- sub_b  out  4  subtrahend nibble to subtractor stage (true b; the stage inverts internally).
- sub_bin  out  1  stage carry-in: 1 = no borrow, 0 = borrow.
- sub_diff  in  4  stage difference.
- sub_bout  in  1  stage carry-out: 1 = no borrow, 0 = borrow.
- diff  out  W  full-width result a−b mod 2^W.
- borrow  out  1  1 when a < b unsigned (= ~final sub_bout).
- ovf  out  1  signed overflow flag (see Configuration).
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse, result valid.

## Operation
- States:
  - IDLE: start=1 → capture a, b; idx=0; go to RUN.
  - RUN: each cycle, latch sub_diff into diff[4·idx+3:4·idx] and carry_q ← sub_bout.
    - idx<NIBBLES−1 → idx+1.
    - idx=NIBBLES−1 → go to DONE.
  - DONE: done=1 for one cycle; borrow=~carry_q; then IDLE. DONE counts as not busy, so a start here is accepted exactly as in IDLE.
- Stage drive (combinational from registers):
  - sub_a = a_q nibble idx; sub_b = b_q nibble idx.
  - sub_bin = 1 when idx=0, else carry_q.
  - Outside RUN: sub_a=0, sub_b=0, sub_bin=1.
- diff, borrow and ovf hold their value from done until the next completion. They are not cleared on a new start, but intermediate nibbles of diff update during RUN.
- start while busy=1 is ignored; no queuing.
- Unsigned arithmetic; the result wraps mod 2^W; borrow reports the wrap.

## Timing
- Reset (async assert, sync-released internally by the integrator) forces the following; it may occur in any state, and an in-flight operation is abandoned with no done:
  - state=IDLE, idx=0, carry_q=1;
  - diff=0, borrow=0, ovf=0, busy=0, done=0.
- Start accepted at edge E0. RUN occupies edges E1..E_NIBBLES, with busy=1 over that interval.
- done=1 in the cycle following E_NIBBLES, so latency = NIBBLES+1 cycles from the start edge to done sampled high.
- Throughput: one operation per NIBBLES+1 cycles when start is held high continuously.
- The subtractor stage is purely combinational. sub_diff and sub_bout must settle within one clock of sub_a, sub_b and sub_bin, which change only at clk edges.

## Configuration
- SUB_OVF_EN defined:
  - ovf is registered at the DONE transition as (a_q[W−1] ≠ b_q[W−1]) && (diff[W−1] ≠ a_q[W−1]), using the final MSB nibble.
  - ovf holds until the next completion.
- SUB_OVF_EN undefined:
  - ovf is tied to 0;
  - no overflow logic is synthesised.

## Test plan
NIBBLES=4, SUB_OVF_EN defined, real 4-bit stage connected.
- a=0x1234, b=0x0234, start one cycle → done pulses 5 cycles after the start edge, diff=0x1000, borrow=0, ovf=0; busy high for exactly 4 cycles.
- a=0x0000, b=0x0001 → diff=0xFFFF, borrow=1, ovf=0; sub_bin observed as 1,0,0,0 across the four RUN cycles.
- a=0x8000, b=0x0001 → diff=0x7FFF, borrow=0, ovf=1. Then a=0x7FFF, b=0xFFFF → diff=0x8000, borrow=1, ovf=1.
- Start with a=0x00FF, b=0x0001; pulse start again with a=0x1111, b=0x1111 two cycles later → second request ignored, done once, diff=0x00FE.
- Start held high continuously with a=0x5555, b=0x1111 → done every 5 cycles, diff=0x4444 each time, busy low only in the done cycles.
- Assert rst_n=0 during the third RUN cycle → all outputs 0 immediately, no done; a fresh start after release yields the correct result.
